// File: rtl/ecc_scrub_pkg.sv
// Shared widths, FSM state encoding and Hamming(12,8) check constants for the
// memory scrubber.
package ecc_scrub_pkg;

  localparam int DEF_CODE_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int SYN_WIDTH      = DEF_CODE_WIDTH - DEF_DATA_WIDTH;

  // Hamming positions (1-based) holding the parity bits; bit index = position - 1.
  localparam int PARITY_POS_0 = 1;
  localparam int PARITY_POS_1 = 2;
  localparam int PARITY_POS_2 = 4;
  localparam int PARITY_POS_3 = 8;

  // Codeword bits covered by each syndrome bit: mask k selects positions with bit k set.
  localparam logic [DEF_CODE_WIDTH-1:0] CHECK_MASK [SYN_WIDTH] = '{
    12'h555,
    12'h666,
    12'h878,
    12'hF80
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_CHECK,
    ST_WRITE,
    ST_DONE
  } scrub_state_t;

  typedef enum logic [1:0] {
    SYN_CLEAN,
    SYN_SINGLE,
    SYN_INVALID
  } syn_class_t;

endpackage

// File: rtl/ecc_syndrome_calc.sv
// Combinational Hamming(12,8) checker: syndrome, single-bit corrected codeword
// and error class for one stored codeword.
module ecc_syndrome_calc
  import ecc_scrub_pkg::*;
(
  input  logic [DEF_CODE_WIDTH-1:0] codeword,
  output logic [SYN_WIDTH-1:0]      syndrome,
  output logic [DEF_CODE_WIDTH-1:0] corrected,
  output syn_class_t                syn_class
);

  always_comb begin
    syndrome = '0;
    for (int k = 0; k < SYN_WIDTH; k++) begin
      syndrome[k] = ^(codeword & CHECK_MASK[k]);
    end
  end

  // A non-zero syndrome names the flipped position; past the last position it is invalid.
  always_comb begin
    syn_class = SYN_CLEAN;
    corrected = codeword;
    if (syndrome == '0) begin
      syn_class = SYN_CLEAN;
    end else if (syndrome <= SYN_WIDTH'(DEF_CODE_WIDTH)) begin
      syn_class = SYN_SINGLE;
      corrected = codeword ^ (DEF_CODE_WIDTH'(1) << (syndrome - SYN_WIDTH'(1)));
    end else begin
      syn_class = SYN_INVALID;
    end
  end

endmodule

// File: rtl/ecc_memory_scrubber.sv
// Background scrubber: walks every address through the shared memory port, checks
// each Hamming(12,8) word and writes back single-bit corrections.
//
// state    | meaning
// ST_IDLE  | waiting for i_start
// ST_READ  | requesting a read of addr, holds until granted
// ST_WAIT  | read in flight, counting remaining latency
// ST_CHECK | i_dout valid, classify and maybe queue a correction
// ST_WRITE | requesting write-back of o_din, holds until granted
// ST_DONE  | one-cycle completion pulse
module ecc_memory_scrubber
  import ecc_scrub_pkg::*;
#(
  parameter int CODE_WIDTH   = DEF_CODE_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = 10,
  parameter int DEPTH        = 2**ADDR_WIDTH,
  parameter int READ_LATENCY = 2,
  parameter int CNT_WIDTH    = 16
)(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_grant,
  input  logic [CODE_WIDTH-1:0] i_dout,
  output logic                  o_en,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [CODE_WIDTH-1:0] o_din,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [CNT_WIDTH-1:0]  o_corr_count,
  output logic [CNT_WIDTH-1:0]  o_uncorr_count,
  output logic [ADDR_WIDTH-1:0] o_last_err_addr
);

  localparam int SW     = CODE_WIDTH - DATA_WIDTH;
  localparam int WAIT_W = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;
  // WAIT lasts READ_LATENCY-1 cycles: load N-2 and leave on terminal count zero.
  localparam logic [WAIT_W-1:0]     WAIT_LOAD = (READ_LATENCY > 2) ? WAIT_W'(READ_LATENCY - 2) : '0;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  scrub_state_t          state;
  scrub_state_t          step_state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] step_addr;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [SW-1:0]         syndrome;
  logic [CODE_WIDTH-1:0] corrected;
  syn_class_t            syn_class;

  ecc_syndrome_calc u_syndrome (
    .codeword  (i_dout),
    .syndrome  (syndrome),
    .corrected (corrected),
    .syn_class (syn_class)
  );

  assign step_state = (addr == LAST_ADDR) ? ST_DONE : ST_READ;
  assign step_addr  = (addr == LAST_ADDR) ? addr : addr + ADDR_WIDTH'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= ST_IDLE;
      addr            <= '0;
      wait_cnt        <= '0;
      o_din           <= '0;
      o_corr_count    <= '0;
      o_uncorr_count  <= '0;
      o_last_err_addr <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (i_start) begin
            addr           <= '0;
            o_corr_count   <= '0;
            o_uncorr_count <= '0;
            state          <= ST_READ;
          end
        end
        ST_READ: begin
          if (i_grant) begin
            if (READ_LATENCY == 1) begin
              state <= ST_CHECK;
            end else begin
              wait_cnt <= WAIT_LOAD;
              state    <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            state <= ST_CHECK;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        ST_CHECK: begin
          if (syndrome == '0) begin
            addr  <= step_addr;
            state <= step_state;
          end else if (syn_class == SYN_SINGLE) begin
            o_din           <= corrected;
            o_last_err_addr <= addr;
            if (o_corr_count != '1) begin
              o_corr_count <= o_corr_count + CNT_WIDTH'(1);
            end
            state <= ST_WRITE;
          end else begin
            o_last_err_addr <= addr;
            if (o_uncorr_count != '1) begin
              o_uncorr_count <= o_uncorr_count + CNT_WIDTH'(1);
            end
            addr  <= step_addr;
            state <= step_state;
          end
        end
        ST_WRITE: begin
          if (i_grant) begin
            addr  <= step_addr;
            state <= step_state;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // The port enable is only raised once the arbiter has granted this cycle.
  assign o_en   = ((state == ST_READ) || (state == ST_WRITE)) && i_grant;
  assign o_we   = (state == ST_WRITE);
  assign o_addr = addr;
  assign o_busy = (state != ST_IDLE);
  assign o_done = (state == ST_DONE);

endmodule
